// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests
// under a credit limit, buffers returned words with their PCs and presents the
// head entry to decode. Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky
// misaligned-redirect fault that halts fetching until reset.
module fetch_cycle #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     FIFO_DEPTH = 2,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            f_to_d_enable_ff,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] PC,
   output logic            instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign_fault
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   state_e             state_q, state_d;
   logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]   out_q, out_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   fetch_entry_t       fifo_q [FIFO_DEPTH];
   fetch_entry_t       fifo_d [FIFO_DEPTH];
   logic               req_valid_q, req_valid_d;
   logic [XLEN-1:0]    instr_q, instr_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;
   logic               fault_q, fault_d;
   logic               halt;
   logic [XLEN-1:0]    redir_pc;
   fetch_entry_t       head;

   logic               accept;
   logic               rsp_fire;
   logic               pop;
   logic               rsp_push;
   logic [XLEN-1:0]    rsp_pc;

   assign accept   = req_valid_q & imem_req_ready;
   assign rsp_fire = imem_rsp_valid & (out_q != '0);
   assign pop      = valid_q & f_to_d_enable_ff;
   assign rsp_push = (state_q == S_RUN) & ~redirect_valid & rsp_fire;
   // Outstanding requests in RUN are contiguous and end just below fetch_pc.
   assign rsp_pc   = fetch_pc_q - (XLEN'(out_q) << 2);

   // Next-state: FSM, PC, credit counter, FIFO and registered decode outputs.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      out_d      = out_q + CNT_W'(accept) - CNT_W'(rsp_fire);
      cnt_d      = cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fifo_d     = fifo_q;
      fault_d    = fault_q;
      halt       = 1'b0;
      redir_pc   = redirect_pc & ~XLEN'(3);

      if (accept) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end

      unique case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN: begin
            if (redirect_valid) begin
               if (out_d != '0) state_d = S_DRAIN;
            end else begin
               if (rsp_push) begin
                  fifo_d[wr_ptr_q] = '{instr: imem_rsp_data, pc: rsp_pc};
                  wr_ptr_d         = wr_ptr_q + PTR_W'(1);
               end
               if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
               cnt_d = cnt_q + CNT_W'(rsp_push) - CNT_W'(pop);
            end
         end
         S_DRAIN: begin
            if (!redirect_valid && out_d == '0) state_d = S_RUN;
         end
         default: state_d = S_BOOT;
      endcase

      // Redirect wins over push and pop: flush and restart at the new PC.
      if (redirect_valid) begin
         cnt_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         redir_pc   = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
`endif
         fetch_pc_d = redir_pc;
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      halt = fault_d;
`endif

      req_valid_d = (state_d == S_RUN) && ((out_d + cnt_d) < CNT_W'(FIFO_DEPTH)) && !halt;
      head        = fifo_d[rd_ptr_d];
      valid_d     = (cnt_d != '0);
      instr_d     = valid_d ? head.instr : NOP_INSTR;
      pc_d        = valid_d ? head.pc : '0;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_BOOT;
         fetch_pc_q  <= RESET_PC;
         out_q       <= '0;
         cnt_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         fifo_q      <= '{default: '0};
         req_valid_q <= 1'b0;
         instr_q     <= NOP_INSTR;
         pc_q        <= '0;
         valid_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         out_q       <= out_d;
         cnt_q       <= cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fifo_q      <= fifo_d;
         req_valid_q <= req_valid_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
         fault_q     <= fault_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = fetch_pc_q;
   assign instruction    = instr_q;
   assign PC             = pc_q;
   assign instr_valid    = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign_fault = fault_q;
`endif

   // A response arriving while the buffer is full breaks the credit protocol.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !rsp_push || pop || (cnt_q < CNT_W'(FIFO_DEPTH)));

endmodule
